ctrl_pipeline: RTL and testbench
================================

// Module: ctrl_pipeline
// PURPOSE
//  Parametrised successor to the single-cycle control decoder: decodes each fetched instruction
//  into a control bundle and carries it through EX/MEM/WB pipeline registers. Detects load-use
//  hazards (stall), kills wrong-path instructions on taken branches (flush) and keeps saturating
//  stall/flush counters. Sits between fetch and the datapath.
// PARAMETERS
//  MCODEBITS  4  opcode field width (>=4); opcode class = Instr[MCODEBITS-1 -: 3]
//  OPWIDTH    3  ALUOp width (>=3)
//  RAW        3  register address width
//  CNTW       16 width of the saturating performance counters
// PORTS
//  Clk          in  1          clock, all state on rising edge
//  Reset_n      in  1          asynchronous, active-low reset
//  InstrValid   in  1          Instr/RsAddr/RdAddr hold a valid decode-stage instruction
//  Instr        in  MCODEBITS  opcode field
//  RsAddr       in  RAW        source register of ID instruction
//  RdAddr       in  RAW        destination (also 2nd source) register of ID instruction
//  BranchTaken  in  1          EX-stage branch resolved taken this cycle
//  Stall        out 1          comb.: hold PC and ID input this cycle
//  Flush        out 1          comb.: discard fetched/ID instruction (= BranchTaken & ExValid & ExBranch)
//  ExValid, ExALUOp[OPWIDTH], ExALUSrc, ExBranch, ExRegDst   out  EX-stage controls
//  MemValid, MemRead, MemWrite                               out  MEM-stage controls
//  WbValid, WbRegWrite, WbMemtoReg, WbAddr[RAW]              out  WB-stage controls
//  IllegalOp    out 1          registered: ID opcode not in table (sticky until reset)
//  StallCount   out CNTW       number of stall cycles, saturates at all-ones
//  FlushCount   out CNTW       number of flushes, saturates at all-ones
// BEHAVIOUR
//  - Reset (Reset_n=0, any time, mid-stall included): all valid bits, control outputs, WbAddr,
//    IllegalOp and counters -> 0 immediately; first valid EX output 1 cycle after first InstrValid.
//  - Decode (class / full opcode): 000 add, 001 mov, 010 xor, 101 shift, 111 and -> RegWrite,
//    RegDst; 011 load -> ALUSrc,MemRead,MemtoReg,RegWrite; 100 store -> ALUSrc,MemWrite;
//    1100 bne -> Branch, ALU SUB, no RegWrite; 1101 set -> ALUSrc,RegWrite. 1110/1111 decode
//    as and. ALUOp codes are fixed in ctrl_pkg.
//  - Invalid slot (bubble): every control bit 0, ALUOp = ALU_PASS.
//  - Pipeline: each edge EX<=ID bundle, MEM<=EX, WB<=MEM; latency ID->EX 1, ->MEM 2, ->WB 3.
//    No enable on EX/MEM/WB; only the ID->EX transfer is modified by hazards.
//  - Load-use: Stall=1 when InstrValid & ExValid & MemRead-class in EX & EX dest==RsAddr or
//    RdAddr (RdAddr compared only for store/xor/add/and/shift/bne). On stall, bubble enters EX;
//    upstream holds inputs; exactly 1 stall cycle per hazard.
//  - Flush: bubble enters EX; current ID instruction dropped. Flush and stall together ->
//    flush wins, Stall forced 0, StallCount not incremented.
//  - IllegalOp sets only for valid, unflushed ID slots; instruction still treated as bubble.
//  - Counters: +1 per cycle Stall=1 / per cycle Flush=1; hold at 2^CNTW-1.
// STRUCTURE
//  ctrl_pkg: typedef struct packed ctrl_t {valid,RegDst,Branch,MemRead,MemWrite,MemtoReg,
//    ALUSrc,RegWrite,ALUOp,dest}; opcode-class localparams; ALUOp enum (ALU_ADD,SUB,XOR,AND,
//    SHIFT,MOV,SET,PASS).
//  Sub-module ctrl_decode: purely combinational opcode -> ctrl_t; ctrl_pipeline owns the
//  stage registers, hazard logic and counters.
// TESTING
//  1 Reset: Reset_n low mid-stream -> all outputs 0 same cycle; counters 0 after release.
//  2 Latency: add (0000) then store (1000) -> ExRegDst=1 @+1, MemWrite=1 @+3, WbRegWrite @+3 for add.
//  3 Load-use: load r2 then add RsAddr=2 -> Stall=1 one cycle, bubble in EX, add reaches EX @+2; StallCount=1.
//  4 Flush: bne in EX with BranchTaken=1 -> Flush=1, ID instr never reaches MEM; FlushCount=1.
//  5 Flush+stall same cycle -> Stall=0, Flush=1, only FlushCount increments.
//  6 Saturation: CNTW=2, 5 stalls -> StallCount=3; illegal opcode (MCODEBITS=5, unused code) -> IllegalOp=1 sticky.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types for the pipelined control decoder: per-stage control bundle,
// opcode classes and ALU operation codes.
package ctrl_pkg;

    // Widest register address the dest field can carry.
    localparam int CTRL_RAW_MAX = 8;

    localparam logic [2:0] CLS_ADD   = 3'b000;
    localparam logic [2:0] CLS_MOV   = 3'b001;
    localparam logic [2:0] CLS_XOR   = 3'b010;
    localparam logic [2:0] CLS_LOAD  = 3'b011;
    localparam logic [2:0] CLS_STORE = 3'b100;
    localparam logic [2:0] CLS_SHIFT = 3'b101;
    localparam logic [2:0] CLS_BRSET = 3'b110;
    localparam logic [2:0] CLS_AND   = 3'b111;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_XOR   = 3'd2,
        ALU_AND   = 3'd3,
        ALU_SHIFT = 3'd4,
        ALU_MOV   = 3'd5,
        ALU_SET   = 3'd6,
        ALU_PASS  = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic                    valid;
        logic                    reg_dst;
        logic                    branch;
        logic                    mem_read;
        logic                    mem_write;
        logic                    memto_reg;
        logic                    alu_src;
        logic                    reg_write;
        alu_op_e                 alu_op;
        logic [CTRL_RAW_MAX-1:0] dest;
    } ctrl_t;

    function automatic ctrl_t ctrl_bubble();
        ctrl_t c;
        c        = '0;
        c.alu_op = ALU_PASS;
        return c;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: maps one opcode (plus its destination register)
// to a control bundle, flags unknown opcodes and reports whether RdAddr is read.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int MCODEBITS = 4,
    parameter int RAW       = 3
) (
    input  logic [MCODEBITS-1:0] instr,
    input  logic [RAW-1:0]       rd_addr,
    output ctrl_t                ctrl,
    output logic                 illegal,
    output logic                 uses_rd
);

    logic [2:0] cls;
    logic       sub_bit;
    logic       ext_zero;

    assign cls     = instr[MCODEBITS-1 -: 3];
    assign sub_bit = instr[MCODEBITS-4];

    // bne/set are full-opcode entries: any opcode bits below the 4-bit code must be zero.
    generate
        if (MCODEBITS > 4) begin : g_ext
            assign ext_zero = ~|instr[MCODEBITS-5:0];
        end else begin : g_no_ext
            assign ext_zero = 1'b1;
        end
    endgenerate

    always_comb begin
        ctrl    = ctrl_bubble();
        illegal = 1'b0;
        uses_rd = 1'b0;
        case (cls)
            CLS_ADD, CLS_XOR, CLS_SHIFT, CLS_AND: begin
                ctrl.valid     = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                uses_rd        = 1'b1;
                ctrl.alu_op    = (cls == CLS_ADD)   ? ALU_ADD :
                                 (cls == CLS_XOR)   ? ALU_XOR :
                                 (cls == CLS_SHIFT) ? ALU_SHIFT : ALU_AND;
            end
            CLS_MOV: begin
                ctrl.valid     = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                ctrl.alu_op    = ALU_MOV;
            end
            CLS_LOAD: begin
                ctrl.valid     = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.memto_reg = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            CLS_STORE: begin
                ctrl.valid     = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                uses_rd        = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            CLS_BRSET: begin
                if (!ext_zero) begin
                    illegal = 1'b1;
                end else if (!sub_bit) begin
                    ctrl.valid  = 1'b1;
                    ctrl.branch = 1'b1;
                    uses_rd     = 1'b1;
                    ctrl.alu_op = ALU_SUB;
                end else begin
                    ctrl.valid     = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_op    = ALU_SET;
                end
            end
            default: illegal = 1'b1;
        endcase
        if (ctrl.valid) begin
            ctrl.dest = CTRL_RAW_MAX'(rd_addr);
        end
    end

endmodule

// File: rtl/ctrl_pipeline.sv
// Control decoder with EX/MEM/WB control registers, load-use stall, branch flush,
// sticky illegal-opcode flag and saturating stall/flush counters.
module ctrl_pipeline
    import ctrl_pkg::*;
#(
    parameter int MCODEBITS = 4,
    parameter int OPWIDTH   = 3,
    parameter int RAW       = 3,
    parameter int CNTW      = 16
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 InstrValid,
    input  logic [MCODEBITS-1:0] Instr,
    input  logic [RAW-1:0]       RsAddr,
    input  logic [RAW-1:0]       RdAddr,
    input  logic                 BranchTaken,
    output logic                 Stall,
    output logic                 Flush,
    output logic                 ExValid,
    output logic [OPWIDTH-1:0]   ExALUOp,
    output logic                 ExALUSrc,
    output logic                 ExBranch,
    output logic                 ExRegDst,
    output logic                 MemValid,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 WbValid,
    output logic                 WbRegWrite,
    output logic                 WbMemtoReg,
    output logic [RAW-1:0]       WbAddr,
    output logic                 IllegalOp,
    output logic [CNTW-1:0]      StallCount,
    output logic [CNTW-1:0]      FlushCount
);

    typedef struct packed {
        logic           valid;
        logic           read;
        logic           write;
        logic           reg_write;
        logic           memto_reg;
        logic [RAW-1:0] addr;
    } mem_t;

    typedef struct packed {
        logic           valid;
        logic           reg_write;
        logic           memto_reg;
        logic [RAW-1:0] addr;
    } wb_t;

    ctrl_t           dec_ctrl;
    logic            dec_illegal;
    logic            dec_uses_rd;
    ctrl_t           ex_d, ex_q;
    mem_t            mem_d, mem_q;
    wb_t             wb_d, wb_q;
    logic            illegal_d, illegal_q;
    logic [CNTW-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNTW-1:0] flush_cnt_d, flush_cnt_q;
    logic            rs_hit, rd_hit, stall_raw, stall, flush;

    ctrl_decode #(
        .MCODEBITS (MCODEBITS),
        .RAW       (RAW)
    ) u_decode (
        .instr   (Instr),
        .rd_addr (RdAddr),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal),
        .uses_rd (dec_uses_rd)
    );

    always_comb begin
        rs_hit    = (ex_q.dest == CTRL_RAW_MAX'(RsAddr));
        rd_hit    = dec_uses_rd && (ex_q.dest == CTRL_RAW_MAX'(RdAddr));
        stall_raw = InstrValid && ex_q.valid && ex_q.mem_read && (rs_hit || rd_hit);
        flush     = BranchTaken && ex_q.valid && ex_q.branch;
        // A taken branch kills the ID instruction, so there is nothing left to stall.
        stall     = stall_raw && !flush;

        ex_d = ctrl_bubble();
        if (InstrValid && !flush && !stall && !dec_illegal) begin
            ex_d = dec_ctrl;
        end

        mem_d.valid     = ex_q.valid;
        mem_d.read      = ex_q.mem_read;
        mem_d.write     = ex_q.mem_write;
        mem_d.reg_write = ex_q.reg_write;
        mem_d.memto_reg = ex_q.memto_reg;
        mem_d.addr      = ex_q.dest[RAW-1:0];

        wb_d.valid     = mem_q.valid;
        wb_d.reg_write = mem_q.reg_write;
        wb_d.memto_reg = mem_q.memto_reg;
        wb_d.addr      = mem_q.addr;

        illegal_d   = illegal_q || (InstrValid && !flush && dec_illegal);
        stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + CNTW'(1) : stall_cnt_q;
        flush_cnt_d = (flush && (flush_cnt_q != '1)) ? flush_cnt_q + CNTW'(1) : flush_cnt_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            illegal_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            illegal_q   <= illegal_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign Stall      = stall;
    assign Flush      = flush;
    assign ExValid    = ex_q.valid;
    assign ExALUOp    = OPWIDTH'(ex_q.alu_op);
    assign ExALUSrc   = ex_q.alu_src;
    assign ExBranch   = ex_q.branch;
    assign ExRegDst   = ex_q.reg_dst;
    assign MemValid   = mem_q.valid;
    assign MemRead    = mem_q.read;
    assign MemWrite   = mem_q.write;
    assign WbValid    = wb_q.valid;
    assign WbRegWrite = wb_q.reg_write;
    assign WbMemtoReg = wb_q.memto_reg;
    assign WbAddr     = wb_q.addr;
    assign IllegalOp  = illegal_q;
    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline: a default instance for decode/pipeline/hazard
// behaviour and a narrow-counter, 5-bit-opcode instance for saturation and illegal opcodes.
module tb_ctrl_pipeline;
    import ctrl_pkg::*;

    localparam logic [3:0] OP_ADD = 4'b0000, OP_MOV = 4'b0010, OP_XOR = 4'b0100;
    localparam logic [3:0] OP_LD  = 4'b0110, OP_ST  = 4'b1000, OP_SHF = 4'b1010;
    localparam logic [3:0] OP_BNE = 4'b1100, OP_SET = 4'b1101, OP_AND = 4'b1110;
    localparam logic [6:0] EX_BUB = {1'b0, ALU_PASS, 3'b000};

    logic clk = 1'b0;
    logic Reset_n;
    always #5 clk = ~clk;

    // Default instance
    logic        InstrValid, BranchTaken;
    logic [3:0]  Instr;
    logic [2:0]  RsAddr, RdAddr;
    logic        Stall, Flush, ExValid, ExALUSrc, ExBranch, ExRegDst;
    logic [2:0]  ExALUOp, WbAddr;
    logic        MemValid, MemRead, MemWrite, WbValid, WbRegWrite, WbMemtoReg, IllegalOp;
    logic [15:0] StallCount, FlushCount;

    ctrl_pipeline dut (
        .Clk(clk), .Reset_n(Reset_n), .InstrValid(InstrValid), .Instr(Instr),
        .RsAddr(RsAddr), .RdAddr(RdAddr), .BranchTaken(BranchTaken),
        .Stall(Stall), .Flush(Flush), .ExValid(ExValid), .ExALUOp(ExALUOp),
        .ExALUSrc(ExALUSrc), .ExBranch(ExBranch), .ExRegDst(ExRegDst),
        .MemValid(MemValid), .MemRead(MemRead), .MemWrite(MemWrite),
        .WbValid(WbValid), .WbRegWrite(WbRegWrite), .WbMemtoReg(WbMemtoReg), .WbAddr(WbAddr),
        .IllegalOp(IllegalOp), .StallCount(StallCount), .FlushCount(FlushCount)
    );

    // Small instance: 5-bit opcodes, 2-bit counters
    logic        s_valid, s_bt;
    logic [4:0]  s_instr;
    logic [2:0]  s_rs, s_rd;
    logic        s_stall, s_flush, s_ex_valid, s_ex_alu_src, s_ex_branch, s_ex_reg_dst;
    logic [2:0]  s_ex_alu_op, s_wb_addr;
    logic        s_mem_valid, s_mem_read, s_mem_write, s_wb_valid, s_wb_reg_write, s_wb_memto_reg;
    logic        s_illegal;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    ctrl_pipeline #(.MCODEBITS(5), .OPWIDTH(3), .RAW(3), .CNTW(2)) dut_s (
        .Clk(clk), .Reset_n(Reset_n), .InstrValid(s_valid), .Instr(s_instr),
        .RsAddr(s_rs), .RdAddr(s_rd), .BranchTaken(s_bt),
        .Stall(s_stall), .Flush(s_flush), .ExValid(s_ex_valid), .ExALUOp(s_ex_alu_op),
        .ExALUSrc(s_ex_alu_src), .ExBranch(s_ex_branch), .ExRegDst(s_ex_reg_dst),
        .MemValid(s_mem_valid), .MemRead(s_mem_read), .MemWrite(s_mem_write),
        .WbValid(s_wb_valid), .WbRegWrite(s_wb_reg_write), .WbMemtoReg(s_wb_memto_reg),
        .WbAddr(s_wb_addr), .IllegalOp(s_illegal), .StallCount(s_stall_cnt),
        .FlushCount(s_flush_cnt)
    );

    int checks   = 0;
    int failures = 0;
    logic [6:0] ex_sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected EX bundle {valid, alu_op, alu_src, branch, reg_dst} for a 4-bit opcode.
    function automatic logic [6:0] ex_exp(input logic [3:0] op);
        case (op[3:1])
            3'b000:  return {1'b1, ALU_ADD,   3'b001};
            3'b001:  return {1'b1, ALU_MOV,   3'b001};
            3'b010:  return {1'b1, ALU_XOR,   3'b001};
            3'b011:  return {1'b1, ALU_ADD,   3'b100};
            3'b100:  return {1'b1, ALU_ADD,   3'b100};
            3'b101:  return {1'b1, ALU_SHIFT, 3'b001};
            3'b110:  return op[0] ? {1'b1, ALU_SET, 3'b100} : {1'b1, ALU_SUB, 3'b010};
            default: return {1'b1, ALU_AND,   3'b001};
        endcase
    endfunction

    // One ID cycle on the default instance: check comb Stall/Flush, then the EX bundle.
    task automatic step(input string tag, input logic v, input logic [3:0] op,
                        input logic [2:0] rs, input logic [2:0] rd, input logic bt,
                        input logic exp_stall, input logic exp_flush, input logic [6:0] exp_ex);
        logic [6:0] e;
        @(negedge clk);
        InstrValid = v; Instr = op; RsAddr = rs; RdAddr = rd; BranchTaken = bt;
        #1;
        chk({tag, ".stall"}, 32'(Stall), 32'(exp_stall));
        chk({tag, ".flush"}, 32'(Flush), 32'(exp_flush));
        ex_sb.push_back(exp_ex);
        @(posedge clk);
        #1;
        e = ex_sb.pop_front();
        chk({tag, ".ex"}, 32'({ExValid, ExALUOp, ExALUSrc, ExBranch, ExRegDst}), 32'(e));
        $display("step %s v=%0b op=%b rs=%0d rd=%0d bt=%0b ex=%b", tag, v, op, rs, rd, bt,
                 {ExValid, ExALUOp, ExALUSrc, ExBranch, ExRegDst});
    endtask

    task automatic step_s(input string tag, input logic v, input logic [4:0] op,
                          input logic [2:0] rs, input logic [2:0] rd, input logic exp_stall);
        @(negedge clk);
        s_valid = v; s_instr = op; s_rs = rs; s_rd = rd; s_bt = 1'b0;
        #1;
        chk({tag, ".stall"}, 32'(s_stall), 32'(exp_stall));
        @(posedge clk);
        #1;
        $display("step_s %s op=%b stall_cnt=%0d illegal=%0b", tag, op, s_stall_cnt, s_illegal);
    endtask

    initial begin
        logic [3:0] ops [6];
        ops = '{OP_MOV, OP_XOR, OP_SHF, OP_SET, OP_AND, 4'b1111};
        Reset_n = 1'b0;
        InstrValid = 1'b0; Instr = '0; RsAddr = '0; RdAddr = '0; BranchTaken = 1'b0;
        s_valid = 1'b0; s_instr = '0; s_rs = '0; s_rd = '0; s_bt = 1'b0;
        #3;
        chk("rst.ex", 32'({ExValid, ExALUOp, ExALUSrc, ExBranch, ExRegDst}), 32'd0);
        chk("rst.wb", 32'({MemValid, WbValid, WbAddr, IllegalOp}), 32'd0);
        chk("rst.cnt", 32'({StallCount, FlushCount}), 32'd0);
        @(negedge clk); @(negedge clk);
        Reset_n = 1'b1;

        // Latency: add then store
        step("add", 1'b1, OP_ADD, 3'd1, 3'd3, 1'b0, 1'b0, 1'b0, ex_exp(OP_ADD));
        step("st", 1'b1, OP_ST, 3'd4, 3'd5, 1'b0, 1'b0, 1'b0, ex_exp(OP_ST));
        chk("lat.mem_add", 32'({MemValid, MemWrite}), 32'b10);
        step("bub", 1'b0, OP_ADD, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, EX_BUB);
        chk("lat.mem_st", 32'({MemValid, MemWrite}), 32'b11);
        chk("lat.wb_add", 32'({WbValid, WbRegWrite, WbMemtoReg, WbAddr}), 32'({3'b110, 3'd3}));

        // Remaining opcode classes
        foreach (ops[i]) step($sformatf("op%0d", i), 1'b1, ops[i], 3'd1, 3'd2, 1'b0,
                              1'b0, 1'b0, ex_exp(ops[i]));

        // Load-use on RsAddr
        step("ld1", 1'b1, OP_LD, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, ex_exp(OP_LD));
        step("use", 1'b1, OP_ADD, 3'd2, 3'd6, 1'b0, 1'b1, 1'b0, EX_BUB);
        chk("lu.cnt", 32'(StallCount), 32'd1);
        chk("lu.mem_ld", 32'({MemValid, MemRead}), 32'b11);
        step("use2", 1'b1, OP_ADD, 3'd2, 3'd6, 1'b0, 1'b0, 1'b0, ex_exp(OP_ADD));
        chk("lu.wb_ld", 32'({WbValid, WbRegWrite, WbMemtoReg, WbAddr}), 32'({3'b111, 3'd2}));

        // Load-use on RdAddr (store reads it, mov does not)
        step("ld2", 1'b1, OP_LD, 3'd0, 3'd4, 1'b0, 1'b0, 1'b0, ex_exp(OP_LD));
        step("st_rd", 1'b1, OP_ST, 3'd1, 3'd4, 1'b0, 1'b1, 1'b0, EX_BUB);
        chk("rd.cnt", 32'(StallCount), 32'd2);
        step("st_rd2", 1'b1, OP_ST, 3'd1, 3'd4, 1'b0, 1'b0, 1'b0, ex_exp(OP_ST));
        step("ld3", 1'b1, OP_LD, 3'd0, 3'd4, 1'b0, 1'b0, 1'b0, ex_exp(OP_LD));
        step("mov_rd", 1'b1, OP_MOV, 3'd1, 3'd4, 1'b0, 1'b0, 1'b0, ex_exp(OP_MOV));
        chk("rd.cnt_hold", 32'(StallCount), 32'd2);

        // Flush
        step("bne", 1'b1, OP_BNE, 3'd1, 3'd7, 1'b0, 1'b0, 1'b0, ex_exp(OP_BNE));
        step("fl", 1'b1, OP_ADD, 3'd0, 3'd5, 1'b1, 1'b0, 1'b1, EX_BUB);
        chk("fl.cnt", 32'(FlushCount), 32'd1);
        step("fl_after", 1'b0, OP_ADD, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, EX_BUB);
        chk("fl.mem", 32'(MemValid), 32'd0);

        // Flush while ID reads the branch's register: flush only
        step("bne2", 1'b1, OP_BNE, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, ex_exp(OP_BNE));
        step("flst", 1'b1, OP_ADD, 3'd2, 3'd2, 1'b1, 1'b0, 1'b1, EX_BUB);
        chk("flst.cnt", 32'({StallCount, FlushCount}), 32'({16'd2, 16'd2}));
        chk("def.illegal", 32'(IllegalOp), 32'd0);

        // Reset mid-stall
        step("ld4", 1'b1, OP_LD, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0, ex_exp(OP_LD));
        @(negedge clk);
        InstrValid = 1'b1; Instr = OP_ADD; RsAddr = 3'd1; RdAddr = 3'd6; BranchTaken = 1'b0;
        #1;
        chk("mr.stall_pre", 32'(Stall), 32'd1);
        #1;
        Reset_n = 1'b0;
        #1;
        chk("mr.stall", 32'({Stall, Flush}), 32'd0);
        chk("mr.ex", 32'({ExValid, ExALUOp, ExALUSrc, ExBranch, ExRegDst}), 32'd0);
        chk("mr.pipe", 32'({MemValid, MemRead, WbValid, WbRegWrite, WbAddr}), 32'd0);
        chk("mr.cnt", 32'({StallCount, FlushCount}), 32'd0);
        @(negedge clk);
        InstrValid = 1'b0;
        Reset_n = 1'b1;
        step("post_rst", 1'b1, OP_ADD, 3'd1, 3'd3, 1'b0, 1'b0, 1'b0, ex_exp(OP_ADD));
        chk("post.cnt", 32'({StallCount, FlushCount}), 32'd0);

        // Small instance: counter saturation
        for (int k = 0; k < 5; k++) begin
            step_s($sformatf("s_ld%0d", k), 1'b1, 5'b01100, 3'd0, 3'd1, 1'b0);
            step_s($sformatf("s_use%0d", k), 1'b1, 5'b00000, 3'd1, 3'd5, 1'b1);
            chk($sformatf("sat.cnt%0d", k), 32'(s_stall_cnt), (k < 3) ? k + 1 : 3);
        end
        chk("s.illegal0", 32'(s_illegal), 32'd0);

        // Small instance: illegal opcode, sticky
        step_s("s_ill", 1'b1, 5'b11001, 3'd0, 3'd0, 1'b0);
        chk("ill.set", 32'({s_illegal, s_ex_valid}), 32'b10);
        step_s("s_bne", 1'b1, 5'b11000, 3'd0, 3'd0, 1'b0);
        chk("ill.sticky", 32'({s_illegal, s_ex_valid, s_ex_branch}), 32'b111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
